flop_stim_seq: RTL and testbench
================================

Name: flop_stim_seq

Overview:
- Upstream stimulus stage for the flop-under-test chain.
- Generates the sequence that drives the chain's sync-reset, async-reset and data inputs: a synchronous-reset pulse, then an async-reset pulse, then a pseudorandom data run of programmable length.
- Start/busy/done handshake, so a bench controller can launch back-to-back runs.

Parameters:
- LEN_W, 8, width of run-length input and cycle counter
- SRST_CYCLES, 2, cycles o_srst is held high (≥1)
- ARST_CYCLES, 2, cycles o_arst is held high (≥1)
- LFSR_SEED, 16'hACE1, LFSR value loaded on each accepted start (must be nonzero)

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_srst  in  1  synchronous active-high reset of this block
- i_start  in  1  start request, sampled in IDLE only
- i_len  in  LEN_W  RUN length in cycles, captured with accepted start
- o_srst  out  1  sync-reset stimulus to downstream chain
- o_arst  out  1  async-reset stimulus to downstream chain (active-high, driven synchronously)
- o_w  out  1  data stimulus
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse at end of sequence
- o_cycle  out  LEN_W  index of current RUN cycle, 0-based

Behaviour:
- Interface: one clock, i_clk; reset i_srst is synchronous and active-high.
- All outputs are registered.
- Reset, i_srst high at an edge:
  - state=IDLE, lfsr=LFSR_SEED, length reg=0, counters=0.
  - All outputs 0.
  - Takes priority over every other input, including mid-sequence; no o_done is produced for an aborted sequence.
- States: IDLE, SRST, ARST, RUN, DONE.
- IDLE:
  - i_start=1 at edge E → SRST from E.
  - Same edge captures i_len and reloads lfsr with LFSR_SEED.
  - i_start=0 → stay.
- SRST:
  - o_srst=1, o_arst=0, o_w=0 for exactly SRST_CYCLES cycles.
  - Then → ARST.
- ARST:
  - o_arst=1, o_srst=0, o_w=0 for exactly ARST_CYCLES cycles.
  - Then → RUN if captured len≠0, else → DONE.
- RUN:
  - Exactly len cycles; o_srst=o_arst=0.
  - o_w = lfsr[0] of the current lfsr value.
  - lfsr advances every RUN cycle, Galois right-shift: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - o_cycle counts 0..len-1, wraps to 0 on exit.
  - len=2^LEN_W-1 is the maximum run; no overflow.
- DONE:
  - o_done=1 for exactly one cycle, all stimulus outputs 0.
  - Then → IDLE.
- o_busy is 1 in SRST, ARST, RUN, DONE; 0 in IDLE.
- o_busy falls the cycle after o_done.
- i_start is ignored while busy.
- i_start high in the cycle after DONE (state IDLE) is accepted: back-to-back runs with one idle cycle between them.
- i_len changes while busy have no effect.
- lfsr holds its value outside RUN and never reaches 0.
- Total sequence length from start edge to o_busy low: SRST_CYCLES+ARST_CYCLES+len+1 cycles.

Test Plan:
- Reset: i_srst=1 for 3 cycles with i_start=1 → all outputs 0, state stays IDLE; release → start accepted on the next edge.
- Defaults, i_len=6:
  - o_srst high 2 cycles, then o_arst high 2 cycles.
  - Then o_w = 1,0,0,0,0,1 with o_cycle = 0..5.
  - Then o_done for 1 cycle; o_busy high 11 cycles total.
- i_len=0: SRST(2) → ARST(2) → DONE; o_w never 1; o_cycle stays 0; o_busy high 5 cycles.
- i_start pulsed repeatedly during RUN, i_len changed to 3 during the run → ignored; run completes with the original length.
- Second run, i_start asserted the cycle after o_done → accepted; o_w again starts 1,0,0,0,0,1 (LFSR reseeded).
- i_srst asserted for 1 cycle in RUN at o_cycle=2 → next cycle all outputs 0, IDLE, no o_done; a following start produces a full, correct sequence.

Source files
------------

// File: rtl/flop_stim_seq.sv
// Stimulus sequencer for the flop-under-test chain: sync-reset pulse, async-reset
// pulse, then a pseudorandom data run of programmable length, with start/busy/done.
module flop_stim_seq #(
  parameter int          LEN_W       = 8,
  parameter int          SRST_CYCLES = 2,
  parameter int          ARST_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_srst,
  output logic             o_arst,
  output logic             o_w,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_cycle
);

  localparam int CNT_MAX = (SRST_CYCLES > ARST_CYCLES) ? SRST_CYCLES : ARST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SRST_LAST = CNT_W'(SRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARST_LAST = CNT_W'(ARST_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SRST,
    ARST,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic [15:0]      lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Outputs are registered, so every branch sets what the *next* cycle shows.
  // lfsr therefore holds the value that feeds o_w in the upcoming RUN cycle.
  always_ff @(posedge i_clk) begin
    // NOTE: all sequential state uses non-blocking assignments so that every
    // register samples pre-edge values regardless of statement order.
    if (i_srst) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      lfsr    <= LFSR_SEED;
      o_srst  <= 1'b0;
      o_arst  <= 1'b0;
      o_w     <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_cycle <= '0;
    end else begin
      o_srst <= 1'b0;
      o_arst <= 1'b0;
      o_w    <= 1'b0;
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state  <= SRST;
            len_q  <= i_len;
            lfsr   <= LFSR_SEED;
            cnt    <= '0;
            o_srst <= 1'b1;
            o_busy <= 1'b1;
          end
        end
        SRST: begin
          if (cnt == SRST_LAST) begin
            state  <= ARST;
            cnt    <= '0;
            o_arst <= 1'b1;
          end else begin
            cnt    <= cnt + 1'b1;
            o_srst <= 1'b1;
          end
        end
        ARST: begin
          if (cnt == ARST_LAST) begin
            cnt <= '0;
            if (len_q != '0) begin
              state   <= RUN;
              o_w     <= lfsr[0];
              lfsr    <= lfsr_next(lfsr);
              o_cycle <= '0;
            end else begin
              state  <= DONE;
              o_done <= 1'b1;
            end
          end else begin
            cnt    <= cnt + 1'b1;
            o_arst <= 1'b1;
          end
        end
        RUN: begin
          if (o_cycle == len_q - 1'b1) begin
            state   <= DONE;
            o_cycle <= '0;
            o_done  <= 1'b1;
          end else begin
            o_cycle <= o_cycle + 1'b1;
            o_w     <= lfsr[0];
            lfsr    <= lfsr_next(lfsr);
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flop_stim_seq.sv
// Self-checking bench for flop_stim_seq: directed scenarios plus randomized runs,
// compared cycle by cycle against a queue-based trace model of the sequence.
module tb_flop_stim_seq;

  localparam int          LEN_W       = 8;
  localparam int          SRST_CYCLES = 2;
  localparam int          ARST_CYCLES = 2;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

  logic             i_clk = 1'b0;
  logic             i_srst;
  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic             o_srst;
  logic             o_arst;
  logic             o_w;
  logic             o_busy;
  logic             o_done;
  logic [LEN_W-1:0] o_cycle;

  flop_stim_seq #(
    .LEN_W      (LEN_W),
    .SRST_CYCLES(SRST_CYCLES),
    .ARST_CYCLES(ARST_CYCLES),
    .LFSR_SEED  (LFSR_SEED)
  ) dut (
    .i_clk  (i_clk),
    .i_srst (i_srst),
    .i_start(i_start),
    .i_len  (i_len),
    .o_srst (o_srst),
    .o_arst (o_arst),
    .o_w    (o_w),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_cycle(o_cycle)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic             srst;
    logic             arst;
    logic             w;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] cycle;
  } outs_t;

  outs_t exp_q[$];
  outs_t cur;
  bit    model_idle = 1'b1;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] galois(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Expected per-cycle output trace of one full accepted sequence.
  task automatic plan_run(input int len);
    outs_t       o;
    logic [15:0] v;
    v = LFSR_SEED;
    for (int i = 0; i < SRST_CYCLES; i++) begin
      o = '0; o.srst = 1'b1; o.busy = 1'b1; exp_q.push_back(o);
    end
    for (int i = 0; i < ARST_CYCLES; i++) begin
      o = '0; o.arst = 1'b1; o.busy = 1'b1; exp_q.push_back(o);
    end
    for (int k = 0; k < len; k++) begin
      o = '0; o.busy = 1'b1; o.w = v[0]; o.cycle = k[LEN_W-1:0];
      exp_q.push_back(o);
      v = galois(v);
    end
    o = '0; o.busy = 1'b1; o.done = 1'b1; exp_q.push_back(o);
  endtask

  function automatic logic [31:0] observed();
    return 32'({o_srst, o_arst, o_w, o_busy, o_done, o_cycle});
  endfunction

  // Drive inputs for the next edge, advance one cycle, update model, compare.
  task automatic tick(input logic s, input logic st, input int l);
    i_srst  = s;
    i_start = st;
    i_len   = l[LEN_W-1:0];
    @(posedge i_clk);
    #1;
    if (s) exp_q.delete();
    else if (model_idle && st) plan_run(l & ((1 << LEN_W) - 1));
    cur = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    model_idle = !cur.busy;
    check("outputs", observed(), 32'(cur));
  endtask

  task automatic run_measure(input int len, input bit noisy, input int ticks,
                             input bit hold_start,
                             output logic [31:0] w_bits, output int busy_cnt);
    w_bits   = '0;
    busy_cnt = 0;
    for (int i = 0; i < ticks; i++) begin
      if (i == 0 || hold_start) tick(1'b0, 1'b1, len);
      else if (noisy && cur.busy) tick(1'b0, 1'($urandom_range(0, 1)), 3);
      else tick(1'b0, 1'b0, len);
      busy_cnt += int'(o_busy);
      if (o_busy && !o_srst && !o_arst && !o_done) w_bits = {w_bits[30:0], o_w};
    end
  endtask

  initial begin
    logic [31:0] w_bits;
    int          busy_cnt;
    bit          found;
    int          len;
    int          guard;

    i_srst  = 1'b1;
    i_start = 1'b1;
    i_len   = 8'd6;

    // Reset held with start high: stays idle.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 6);
    check("reset_outs", observed(), 32'd0);

    // Release: first start accepted, default length 6.
    run_measure(6, 1'b0, 13, 1'b0, w_bits, busy_cnt);
    check("len6_w_pattern", w_bits, 32'b100001);
    check("len6_busy", 32'(busy_cnt), 32'd11);

    // Zero-length run.
    run_measure(0, 1'b0, 7, 1'b0, w_bits, busy_cnt);
    check("len0_w", w_bits, 32'd0);
    check("len0_busy", 32'(busy_cnt), 32'd5);

    // Start pulses and len=3 during the run are ignored.
    run_measure(8, 1'b1, 14, 1'b0, w_bits, busy_cnt);
    check("noisy_busy", 32'(busy_cnt), 32'd13);

    // Back-to-back: start held high, second run begins right after the idle cycle.
    run_measure(6, 1'b0, 24, 1'b1, w_bits, busy_cnt);
    check("b2b_w_pattern", w_bits, 32'h861);
    check("b2b_busy", 32'(busy_cnt), 32'd22);
    tick(1'b0, 1'b0, 6);

    // Abort mid-run at o_cycle=2.
    tick(1'b0, 1'b1, 10);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (cur.busy && !cur.srst && !cur.arst && !cur.done && cur.cycle == 8'd2) found = 1'b1;
      else tick(1'b0, 1'b0, 10);
    end
    check("abort_reached", 32'(found), 32'd1);
    tick(1'b1, 1'b0, 10);
    check("abort_outs", observed(), 32'd0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 10);
    run_measure(6, 1'b0, 13, 1'b0, w_bits, busy_cnt);
    check("post_abort_w", w_bits, 32'b100001);
    check("post_abort_busy", 32'(busy_cnt), 32'd11);

    // Randomized runs, including the maximum length.
    for (int r = 0; r < 40; r++) begin
      len = (r == 5) ? 255 : int'($urandom_range(0, 20));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick(1'b0, 1'b0, len);
      tick(1'b0, 1'b1, len);
      guard = 0;
      while (!model_idle && guard < 300) begin
        if (($urandom_range(0, 99) == 0) && (r != 5)) tick(1'b1, 1'b0, len);
        else tick(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
        guard++;
      end
      if (guard >= 300) check("run_timeout", 32'd1, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
